// File: rtl/sync_fifo_ctrl_flags.sv
// Single-clock FIFO with registered full/empty/almost flags, both polarities,
// occupancy count, and a standard or first-word-fall-through read port.
// Ports: clk, rst_n; wen/din/full(_n)/almost_full(_n) on the write side;
//        ren/dout/empty(_n)/almost_empty(_n) on the read side; data_cnt.
module sync_fifo_ctrl_flags #(
  parameter int data_width      = 32,
  parameter int depth           = 32,
  parameter int almost_full_th  = 30,
  parameter int almost_empty_th = 2,
  parameter int fwft_mode       = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wen,
  input  logic [data_width-1:0]        din,
  output logic                         full,
  output logic                         full_n,
  output logic                         almost_full,
  output logic                         almost_full_n,
  input  logic                         ren,
  output logic [data_width-1:0]        dout,
  output logic                         empty,
  output logic                         empty_n,
  output logic                         almost_empty,
  output logic                         almost_empty_n,
  output logic [$clog2(depth):0]       data_cnt
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(depth);
  localparam logic [CW-1:0] AF_TH    = CW'(almost_full_th);
  localparam logic [CW-1:0] AE_TH    = CW'(almost_empty_th);

  if ((depth < 4) || ((depth & (depth - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_ctrl_flags: depth must be a power of two >= 4");
  end
  if ((almost_full_th < 1) || (almost_full_th > depth)) begin : g_bad_af
    $error("sync_fifo_ctrl_flags: almost_full_th must be in 1..depth");
  end
  if ((almost_empty_th < 0) || (almost_empty_th > depth - 1)) begin : g_bad_ae
    $error("sync_fifo_ctrl_flags: almost_empty_th must be in 0..depth-1");
  end

  logic [data_width-1:0] r_mem [depth];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [CW-1:0]         w_cnt_nxt;

  // Acceptance uses the registered flags, so wen+ren on an empty FIFO only
  // writes and on a full FIFO only reads.
  assign w_wr_acc = wen & ~r_full;
  assign w_rd_acc = ren & ~r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_nxt = r_cnt + CW'(1);
      2'b01:   w_cnt_nxt = r_cnt - CW'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
      r_cnt    <= w_cnt_nxt;
      // Flags follow the next count so they line up with data_cnt.
      r_full   <= (w_cnt_nxt == FULL_CNT);
      r_empty  <= (w_cnt_nxt == '0);
      r_afull  <= (w_cnt_nxt >= AF_TH);
      r_aempty <= (w_cnt_nxt <= AE_TH);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= din;
  end

  if (fwft_mode != 0) begin : g_fwft
    assign dout = r_mem[r_rptr];
  end else begin : g_std
    logic [data_width-1:0] r_dout;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_dout <= '0;
      else if (w_rd_acc) r_dout <= r_mem[r_rptr];
    end
    assign dout = r_dout;
  end

  assign full           = r_full;
  assign full_n         = ~r_full;
  assign almost_full    = r_afull;
  assign almost_full_n  = ~r_afull;
  assign empty          = r_empty;
  assign empty_n        = ~r_empty;
  assign almost_empty   = r_aempty;
  assign almost_empty_n = ~r_aempty;
  assign data_cnt       = r_cnt;

endmodule

// File: tb/tb_sync_fifo_ctrl_flags.sv
// Bench for sync_fifo_ctrl_flags: standard and FWFT instances share stimulus
// and are checked against a queue-based occupancy/data model.
module tb_sync_fifo_ctrl_flags;

  localparam int DW  = 16;
  localparam int DEP = 8;
  localparam int AF  = 6;
  localparam int AE  = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wen = 1'b0;
  logic          ren = 1'b0;
  logic [DW-1:0] din = '0;

  logic          s_full, s_full_n, s_af, s_af_n;
  logic          s_empty, s_empty_n, s_ae, s_ae_n;
  logic [DW-1:0] s_dout;
  logic [3:0]    s_cnt;

  logic          f_full, f_full_n, f_af, f_af_n;
  logic          f_empty, f_empty_n, f_ae, f_ae_n;
  logic [DW-1:0] f_dout;
  logic [3:0]    f_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_std;

  always #5 clk = ~clk;

  sync_fifo_ctrl_flags #(
    .data_width(DW), .depth(DEP), .almost_full_th(AF),
    .almost_empty_th(AE), .fwft_mode(0)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .wen(wen), .din(din),
    .full(s_full), .full_n(s_full_n),
    .almost_full(s_af), .almost_full_n(s_af_n),
    .ren(ren), .dout(s_dout),
    .empty(s_empty), .empty_n(s_empty_n),
    .almost_empty(s_ae), .almost_empty_n(s_ae_n),
    .data_cnt(s_cnt)
  );

  sync_fifo_ctrl_flags #(
    .data_width(DW), .depth(DEP), .almost_full_th(AF),
    .almost_empty_th(AE), .fwft_mode(1)
  ) u_fw (
    .clk(clk), .rst_n(rst_n), .wen(wen), .din(din),
    .full(f_full), .full_n(f_full_n),
    .almost_full(f_af), .almost_full_n(f_af_n),
    .ren(ren), .dout(f_dout),
    .empty(f_empty), .empty_n(f_empty_n),
    .almost_empty(f_ae), .almost_empty_n(f_ae_n),
    .data_cnt(f_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    logic xf, xe, xaf, xae;
    n   = q.size();
    xf  = (n == DEP);
    xe  = (n == 0);
    xaf = (n >= AF);
    xae = (n <= AE);
    chk("std_cnt",   32'(s_cnt), 32'(n));
    chk("std_full",  32'(s_full), 32'(xf));
    chk("std_fulln", 32'(s_full_n), 32'(!xf));
    chk("std_empty", 32'(s_empty), 32'(xe));
    chk("std_emptn", 32'(s_empty_n), 32'(!xe));
    chk("std_af",    32'(s_af), 32'(xaf));
    chk("std_afn",   32'(s_af_n), 32'(!xaf));
    chk("std_ae",    32'(s_ae), 32'(xae));
    chk("std_aen",   32'(s_ae_n), 32'(!xae));
    chk("std_dout",  32'(s_dout), 32'(exp_std));
    chk("fw_cnt",    32'(f_cnt), 32'(n));
    chk("fw_full",   32'(f_full), 32'(xf));
    chk("fw_fulln",  32'(f_full_n), 32'(!xf));
    chk("fw_empty",  32'(f_empty), 32'(xe));
    chk("fw_emptn",  32'(f_empty_n), 32'(!xe));
    chk("fw_af",     32'(f_af), 32'(xaf));
    chk("fw_afn",    32'(f_af_n), 32'(!xaf));
    chk("fw_ae",     32'(f_ae), 32'(xae));
    chk("fw_aen",    32'(f_ae_n), 32'(!xae));
    if (n > 0) chk("fw_dout", 32'(f_dout), 32'(q[0]));
  endtask

  // One clock of traffic; the model decides acceptance from the
  // occupancy before the edge, exactly as a FIFO user would.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit wa, ra;
    wen = w;
    ren = r;
    din = d;
    @(posedge clk);
    wa = w && (q.size() < DEP);
    ra = r && (q.size() > 0);
    if (ra) exp_std = q.pop_front();
    if (wa) q.push_back(d);
    #1;
    wen = 1'b0;
    ren = 1'b0;
    check_all();
  endtask

  initial begin
    exp_std = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();

    // Fill to full then one ignored write.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i));
    chk("full_cnt8", 32'(s_cnt), 32'd8);
    step(1'b1, 1'b0, 16'h0009);
    chk("ovf_cnt8", 32'(s_cnt), 32'd8);

    // Drain, then one read on empty.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, '0);
      chk("drain_dout", 32'(s_dout), 32'(i));
    end
    step(1'b0, 1'b1, '0);
    chk("under_dout", 32'(s_dout), 32'h0008);

    // FWFT latency.
    step(1'b1, 1'b0, 16'hBEEF);
    chk("fwft_dout", 32'(f_dout), 32'hBEEF);
    chk("fwft_nempt", 32'(f_empty), 32'd0);
    step(1'b0, 1'b1, '0);
    chk("fwft_pop", 32'(f_cnt), 32'd0);

    // wen+ren on empty: only the write lands, std dout unchanged.
    step(1'b1, 1'b1, 16'h1234);
    chk("e_wr_cnt", 32'(s_cnt), 32'd1);
    chk("e_wr_dout", 32'(s_dout), 32'hBEEF);

    // Occupancy 4, then 20 simultaneous cycles across the wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, DW'($urandom));
      chk("sim_cnt4", 32'(s_cnt), 32'd4);
    end

    // wen+ren on full: only the read lands.
    while (q.size() < DEP) step(1'b1, 1'b0, DW'($urandom));
    step(1'b1, 1'b1, 16'hDEAD);
    chk("f_rd_cnt", 32'(s_cnt), 32'd7);

    // Mid-operation asynchronous reset at occupancy 5.
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_std = '0;
    check_all();
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h00AA);
    step(1'b0, 1'b1, '0);
    chk("rst_aa", 32'(s_dout), 32'h00AA);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), DW'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
